// File: rtl/output_writeback_fifo.sv
// Write-back buffer between the accelerator core and the L2 streamer.
// Absorbs core write-backs in a FWFT FIFO and tracks end-of-network drain.
//
// Ports:
//   clk, reset (async, active-low), clear (sync flush)
//   wr_output_enable/addr/data : write-back triple from the core
//   finished_network           : core done (level or pulse, edge-detected)
//   out_valid/ready/addr/data  : head of FIFO as a valid/ready stream
//   out_last                   : final beat of the drain
//   level, almost_full, overflow (sticky), busy, drain_done (1-cycle)
// Optional: OUTPUT_WRITEBACK_ADDR_WINDOW_EN adds win_base/win_limit inputs
//   and filtered_cnt; out-of-window writes are discarded and counted.

module output_writeback_fifo #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            wr_output_enable,
    input  logic [ADDR_WIDTH-1:0]           wr_output_addr,
    input  logic [DATA_WIDTH-1:0]           wr_output_data,
    input  logic                            finished_network,
`ifdef OUTPUT_WRITEBACK_ADDR_WINDOW_EN
    input  logic [ADDR_WIDTH-1:0]           win_base,
    input  logic [ADDR_WIDTH-1:0]           win_limit,
    output logic [15:0]                     filtered_cnt,
`endif
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ADDR_WIDTH-1:0]           out_addr,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_last,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            almost_full,
    output logic                            overflow,
    output logic                            busy,
    output logic                            drain_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] AFULL_L = LW'(AFULL_THRESH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q;
    logic          fin_q;
    state_t        state_q;

    logic cand, push, pop, full, fin_rise;
    logic [EW-1:0] head;

`ifdef OUTPUT_WRITEBACK_ADDR_WINDOW_EN
    logic        in_win;
    logic [15:0] filt_q;

    assign in_win = (wr_output_addr >= win_base) &&
                    (wr_output_addr <= win_limit);
    assign cand   = wr_output_enable && in_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= '0;
        end else if (clear) begin
            filt_q <= '0;
        end else if (wr_output_enable && !in_win && filt_q != 16'hFFFF) begin
            filt_q <= filt_q + 16'd1;
        end
    end

    assign filtered_cnt = filt_q;
`else
    assign cand = wr_output_enable;
`endif

    assign full     = (level_q == DEPTH_L);
    assign out_valid = (level_q != '0);
    assign pop      = out_valid && out_ready;
    // A full FIFO still accepts a write when the head leaves this cycle.
    assign push     = cand && (!full || pop);
    // Edge detect so a level-held finish does not re-arm after DONE.
    assign fin_rise = finished_network && !fin_q;

    assign head     = mem_q[rd_ptr_q];
    assign out_addr = out_valid ? head[EW-1:DATA_WIDTH] : '0;
    assign out_data = out_valid ? head[DATA_WIDTH-1:0] : '0;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= {wr_output_addr, wr_output_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            fin_q      <= 1'b0;
            state_q    <= IDLE;
        end else begin
            fin_q <= finished_network;
            if (clear) begin
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                level_q    <= '0;
                overflow_q <= 1'b0;
                state_q    <= IDLE;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                level_q <= level_d;
                if (cand && !push) overflow_q <= 1'b1;
                unique case (state_q)
                    IDLE: begin
                        if (fin_rise)  state_q <= DRAIN;
                        else if (cand) state_q <= RUN;
                    end
                    RUN: begin
                        if (fin_rise) state_q <= DRAIN;
                    end
                    DRAIN: begin
                        if (level_q == '0 && !push) state_q <= DONE;
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign level       = level_q;
    assign almost_full = (level_q >= AFULL_L);
    assign overflow    = overflow_q;
    assign busy        = (state_q != IDLE);
    assign drain_done  = (state_q == DONE);
    assign out_last    = (state_q == DRAIN) && (level_q == LW'(1)) &&
                         !wr_output_enable;

endmodule

// File: tb/tb_output_writeback_fifo.sv
// Directed bench for output_writeback_fifo.
// Hand-computed expectations for pass-through, overflow, drain and clear.

module tb_output_writeback_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic        fin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [63:0] out_data;
    logic        out_last;
    logic [4:0]  level;
    logic        almost_full;
    logic        overflow;
    logic        busy;
    logic        drain_done;
`ifdef OUTPUT_WRITEBACK_ADDR_WINDOW_EN
    logic [31:0] win_base;
    logic [31:0] win_limit;
    logic [15:0] filtered_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    output_writeback_fifo dut (
        .clk              (clk),
        .reset            (reset),
        .clear            (clear),
        .wr_output_enable (wr_en),
        .wr_output_addr   (wr_addr),
        .wr_output_data   (wr_data),
        .finished_network (fin),
`ifdef OUTPUT_WRITEBACK_ADDR_WINDOW_EN
        .win_base         (win_base),
        .win_limit        (win_limit),
        .filtered_cnt     (filtered_cnt),
`endif
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_addr         (out_addr),
        .out_data         (out_data),
        .out_last         (out_last),
        .level            (level),
        .almost_full      (almost_full),
        .overflow         (overflow),
        .busy             (busy),
        .drain_done       (drain_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; fin = 1'b0; out_ready = 1'b0;
`ifdef OUTPUT_WRITEBACK_ADDR_WINDOW_EN
        win_base = '0; win_limit = '1;
`endif
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", drain_done, 0);
        chk("rst_last", out_last, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_data", out_data, 0);
        reset = 1'b1;
        tick();

        // pass-through
        out_ready = 1'b1;
        wr(32'h10, 64'h0102030405060708);
        chk("pt_valid", out_valid, 1);
        chk("pt_addr", out_addr, 32'h10);
        chk("pt_data", out_data, 64'h0102030405060708);
        chk("pt_level1", level, 1);
        chk("pt_busy", busy, 1);
        tick();
        chk("pt_level0", level, 0);
        chk("pt_empty", out_valid, 0);

        // overflow
        out_ready = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            wr(32'(i), 64'(i));
            chk("ov_level", level, (i + 1 > 16) ? 16 : i + 1);
            chk("ov_af", almost_full, (i + 1 >= 12) ? 1 : 0);
            chk("ov_flag", overflow, (i == 16) ? 1 : 0);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("ov_pop_valid", out_valid, 1);
            chk("ov_pop_addr", out_addr, j);
            tick();
        end
        chk("ov_drained", out_valid, 0);
        chk("ov_sticky", overflow, 1);
        out_ready = 1'b0;

        // full with simultaneous push and pop
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_busy", busy, 0);
        for (int i = 0; i < 16; i++) wr(32'h40 + 32'(i), 64'(i));
        chk("fp_full", level, 16);
        out_ready = 1'b1;
        wr(32'h99, 64'h99);
        out_ready = 1'b0;
        chk("fp_level", level, 16);
        chk("fp_ovf", overflow, 0);
        chk("fp_head", out_addr, 32'h41);
        out_ready = 1'b1;
        for (int j = 1; j < 16; j++) begin
            chk("fp_pop", out_addr, 32'h40 + 32'(j));
            tick();
        end
        chk("fp_last_addr", out_addr, 32'h99);
        tick();
        chk("fp_empty", level, 0);
        out_ready = 1'b0;

        // drain
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) wr(32'h200 + 32'(i), 64'(i));
        fin = 1'b1;
        tick();
        fin = 1'b0;
        chk("dr_busy", busy, 1);
        chk("dr_nolast", out_last, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("dr_addr", out_addr, 32'h200 + 32'(k));
            chk("dr_last", out_last, (k == 2) ? 1 : 0);
            chk("dr_nodone", drain_done, 0);
            tick();
        end
        chk("dr_empty", out_valid, 0);
        chk("dr_pre_done", drain_done, 0);
        tick();
        chk("dr_done", drain_done, 1);
        chk("dr_done_busy", busy, 1);
        tick();
        chk("dr_done_off", drain_done, 0);
        chk("dr_idle", busy, 0);
        out_ready = 1'b0;

        // empty-network drain, finish held high
        fin = 1'b1;
        tick();
        chk("en_busy", busy, 1);
        chk("en_nodone", drain_done, 0);
        tick();
        chk("en_done", drain_done, 1);
        tick();
        chk("en_done_off", drain_done, 0);
        chk("en_idle", busy, 0);
        tick();
        chk("en_no_retrig", busy, 0);
        fin = 1'b0;

        // clear beats a same-cycle write
        for (int i = 0; i < 5; i++) wr(32'h300 + 32'(i), 64'(i));
        chk("cl_level5", level, 5);
        clear = 1'b1;
        wr(32'h555, 64'h555);
        clear = 1'b0;
        chk("cl_level", level, 0);
        chk("cl_ovf", overflow, 0);
        chk("cl_idle", busy, 0);
        chk("cl_valid", out_valid, 0);
        tick();
        chk("cl_valid2", out_valid, 0);

        // reset in the middle of a drain
        wr(32'h400, 64'h1);
        wr(32'h401, 64'h2);
        fin = 1'b1;
        tick();
        fin = 1'b0;
        chk("rm_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("rm_level", level, 0);
        chk("rm_busy0", busy, 0);
        chk("rm_valid", out_valid, 0);
        chk("rm_done", drain_done, 0);
        tick();
        reset = 1'b1;
        repeat (3) begin
            tick();
            chk("rm_no_done", drain_done, 0);
        end

`ifdef OUTPUT_WRITEBACK_ADDR_WINDOW_EN
        win_base  = 32'h100;
        win_limit = 32'h1FF;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("wn_cnt0", filtered_cnt, 0);
        wr(32'h0FF, 64'hA);
        chk("wn_idle", busy, 0);
        wr(32'h100, 64'hB);
        wr(32'h1FF, 64'hC);
        wr(32'h200, 64'hD);
        chk("wn_level", level, 2);
        chk("wn_cnt", filtered_cnt, 2);
        chk("wn_ovf", overflow, 0);
        chk("wn_head0", out_addr, 32'h100);
        out_ready = 1'b1;
        tick();
        chk("wn_head1", out_addr, 32'h1FF);
        chk("wn_data1", out_data, 64'hC);
        tick();
        chk("wn_empty", out_valid, 0);
        out_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
